// File: rtl/rom_arbiter.sv
// Two-port arbiter/sequencer in front of a combinational instruction ROM.
// Range-checks byte addresses, inserts wait states and returns registered, port-tagged responses.
module rom_arbiter #(
    parameter int unsigned           MEMORY_DEPTH = 64,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h0040_0000,
    parameter int unsigned           WAIT_STATES  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid_i,
    input  logic [DATA_WIDTH-1:0] req0_addr_i,
    output logic                  req0_ready_o,
    input  logic                  req1_valid_i,
    input  logic [DATA_WIDTH-1:0] req1_addr_i,
    output logic                  req1_ready_o,
    output logic                  rsp0_valid_o,
    output logic [DATA_WIDTH-1:0] rsp0_data_o,
    output logic                  rsp0_err_o,
    output logic                  rsp1_valid_o,
    output logic [DATA_WIDTH-1:0] rsp1_data_o,
    output logic                  rsp1_err_o,
    output logic [DATA_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i
);

    // One bit wider than an address so the end-of-ROM bound cannot wrap.
    localparam logic [DATA_WIDTH:0] LimitAddr =
        {1'b0, BASE_ADDR} + (DATA_WIDTH + 1)'(4 * MEMORY_DEPTH);
    localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic                  owner_q, owner_d;
    logic                  fault_q, fault_d;
    logic                  rr_q, rr_d;
    logic                  rsp0_valid_q, rsp0_valid_d;
    logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
    logic                  rsp0_err_q, rsp0_err_d;
    logic                  rsp1_valid_q, rsp1_valid_d;
    logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;
    logic                  rsp1_err_q, rsp1_err_d;

    logic                  accept_win;
    logic                  gnt0, gnt1;
    logic [DATA_WIDTH-1:0] sel_addr;

    function automatic logic addr_fault(input logic [DATA_WIDTH-1:0] addr);
        return (addr < BASE_ADDR) || ({1'b0, addr} >= LimitAddr) || (addr[1:0] != 2'b00);
    endfunction

    always_comb begin
        accept_win = (state_q == StIdle) || (cnt_q == 4'd0);
        // Grants are held off while reset is asserted so ready reads as 0 in reset.
        gnt0 = reset && accept_win && req0_valid_i && (!req1_valid_i || !rr_q);
        gnt1 = reset && accept_win && req1_valid_i && (!req0_valid_i || rr_q);
        sel_addr = gnt1 ? req1_addr_i : req0_addr_i;

        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        owner_d      = owner_q;
        fault_d      = fault_q;
        rr_d         = rr_q;
        rsp0_valid_d = 1'b0;
        rsp0_data_d  = rsp0_data_q;
        rsp0_err_d   = rsp0_err_q;
        rsp1_valid_d = 1'b0;
        rsp1_data_d  = rsp1_data_q;
        rsp1_err_d   = rsp1_err_q;

        unique case (state_q)
            StIdle: ;
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    if (!owner_q) begin
                        rsp0_valid_d = 1'b1;
                        rsp0_data_d  = fault_q ? '0 : rom_data_i;
                        rsp0_err_d   = fault_q;
                    end else begin
                        rsp1_valid_d = 1'b1;
                        rsp1_data_d  = fault_q ? '0 : rom_data_i;
                        rsp1_err_d   = fault_q;
                    end
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A grant in the completion cycle overrides the return to idle (back-to-back).
        if (gnt0 || gnt1) begin
            addr_d  = sel_addr;
            owner_d = gnt1;
            fault_d = addr_fault(sel_addr);
            cnt_d   = WaitInit;
            rr_d    = gnt0;
            state_d = StAccess;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            addr_q       <= BASE_ADDR;
            owner_q      <= 1'b0;
            fault_q      <= 1'b0;
            rr_q         <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= '0;
            rsp1_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            owner_q      <= owner_d;
            fault_q      <= fault_d;
            rr_q         <= rr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_data_q  <= rsp1_data_d;
            rsp1_err_q   <= rsp1_err_d;
        end
    end

    always_comb begin
        req0_ready_o = gnt0;
        req1_ready_o = gnt1;
        rsp0_valid_o = rsp0_valid_q;
        rsp0_data_o  = rsp0_data_q;
        rsp0_err_o   = rsp0_err_q;
        rsp1_valid_o = rsp1_valid_q;
        rsp1_data_o  = rsp1_data_q;
        rsp1_err_o   = rsp1_err_q;
        // Faulted accesses park the ROM on word 0 so it never sees an out-of-range address.
        rom_addr_o   = (state_q == StAccess && !fault_q) ? addr_q : BASE_ADDR;
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: one instance with no wait states, one with three, a ROM model each,
// and a scoreboard that predicts every response at acceptance time.
module tb_rom_arbiter;

    localparam logic [31:0] Base = 32'h0040_0000;

    typedef struct {
        int          dut;
        logic        port;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  v0, v1;
    logic [31:0] a0 [2];
    logic [31:0] a1 [2];
    wire  [1:0]  rdy0, rdy1, rv0, rv1, re0, re1;
    wire  [31:0] rd0 [2];
    wire  [31:0] rd1 [2];
    wire  [31:0] rom_addr [2];
    wire  [31:0] rom_data [2];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        return 32'h5A00_0000 + idx * 32'h0001_0203;
    endfunction

    assign rom_data[0] = rom_word((rom_addr[0] - Base) >> 2);
    assign rom_data[1] = rom_word((rom_addr[1] - Base) >> 2);

    rom_arbiter #(.WAIT_STATES(0)) dut_w0 (
        .clk(clk), .reset(reset),
        .req0_valid_i(v0[0]), .req0_addr_i(a0[0]), .req0_ready_o(rdy0[0]),
        .req1_valid_i(v1[0]), .req1_addr_i(a1[0]), .req1_ready_o(rdy1[0]),
        .rsp0_valid_o(rv0[0]), .rsp0_data_o(rd0[0]), .rsp0_err_o(re0[0]),
        .rsp1_valid_o(rv1[0]), .rsp1_data_o(rd1[0]), .rsp1_err_o(re1[0]),
        .rom_addr_o(rom_addr[0]), .rom_data_i(rom_data[0])
    );

    rom_arbiter #(.WAIT_STATES(3)) dut_w3 (
        .clk(clk), .reset(reset),
        .req0_valid_i(v0[1]), .req0_addr_i(a0[1]), .req0_ready_o(rdy0[1]),
        .req1_valid_i(v1[1]), .req1_addr_i(a1[1]), .req1_ready_o(rdy1[1]),
        .rsp0_valid_o(rv0[1]), .rsp0_data_o(rd0[1]), .rsp0_err_o(re0[1]),
        .rsp1_valid_o(rv1[1]), .rsp1_data_o(rd1[1]), .rsp1_err_o(re1[1]),
        .rom_addr_o(rom_addr[1]), .rom_data_i(rom_data[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic p, input logic [31:0] a);
        exp_t e;
        logic f;
        f      = (a < Base) || (a >= Base + 32'd256) || (a[1:0] != 2'b00);
        e.dut  = d;
        e.port = p;
        e.err  = f;
        e.data = f ? 32'd0 : rom_word((a - Base) >> 2);
        e.due  = cyc + 2 + ((d == 0) ? 0 : 3);
        sb.push_back(e);
    endtask

    task automatic mon(input int d);
        int         idx;
        exp_t       e;
        logic [1:0] rv;
        rv  = {rv1[d], rv0[d]};
        idx = -1;
        for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].dut == d) idx = i;
        if (rv != 2'b00) begin
            if (idx < 0) begin
                check("unexpected_rsp", 32'(rv), 32'd0);
            end else begin
                e = sb[idx];
                sb.delete(idx);
                check("rsp_port", 32'(rv), e.port ? 32'd2 : 32'd1);
                check("rsp_data", e.port ? rd1[d] : rd0[d], e.data);
                check("rsp_err", 32'(e.port ? re1[d] : re0[d]), 32'(e.err));
                check("rsp_cycle", 32'(cyc), 32'(e.due));
            end
        end else if (idx >= 0 && sb[idx].due <= cyc) begin
            e = sb[idx];
            sb.delete(idx);
            check("rsp_missing", 32'(rv), e.port ? 32'd2 : 32'd1);
        end
        if (reset && rdy0[d]) push(d, 1'b0, a0[d]);
        if (reset && rdy1[d]) push(d, 1'b1, a1[d]);
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input int d, input string tag);
        check({tag, "_rsp_valid"}, 32'({rv1[d], rv0[d]}), 32'd0);
        check({tag, "_rsp0_data"}, rd0[d], 32'd0);
        check({tag, "_rsp1_data"}, rd1[d], 32'd0);
        check({tag, "_rsp_err"}, 32'({re1[d], re0[d]}), 32'd0);
        check({tag, "_ready"}, 32'({rdy1[d], rdy0[d]}), 32'd0);
        check({tag, "_rom_addr"}, rom_addr[d], Base);
    endtask

    initial begin
        logic [31:0] faddr [3];
        faddr[0] = 32'h003F_FFFC;
        faddr[1] = 32'h0040_0100;
        faddr[2] = 32'h0040_0002;

        // Reset with requests already pending on the W=0 instance.
        reset = 1'b0;
        v0 = 2'b01;
        v1 = 2'b01;
        a0[0] = 32'h0040_0000;
        a1[0] = 32'h0040_0004;
        a0[1] = Base;
        a1[1] = Base;
        tick();
        tick();
        check_reset_vals(0, "rst_w0");
        check_reset_vals(1, "rst_w3");

        // Contention, W=0: grants must alternate starting at port 0.
        reset = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("rr_ready0", 32'(rdy0[0]), 32'(i % 2 == 0));
            check("rr_ready1", 32'(rdy1[0]), 32'(i % 2 == 1));
            tick();
        end
        v0[0] = 1'b0;
        v1[0] = 1'b0;
        tick(); tick(); tick();

        // Single fetch, W=0.
        v0[0] = 1'b1;
        a0[0] = 32'h0040_0008;
        #1;
        check("fetch_ready", 32'(rdy0[0]), 32'd1);
        tick();
        v0[0] = 1'b0;
        check("fetch_no_early_rsp", 32'(rv0[0]), 32'd0);
        check("fetch_rom_addr", rom_addr[0], 32'h0040_0008);
        tick();
        check("fetch_rsp_valid", 32'(rv0[0]), 32'd1);
        check("fetch_rsp_data", rd0[0], rom_word(32'd2));
        check("fetch_rsp_err", 32'(re0[0]), 32'd0);
        tick();
        check("fetch_rsp_pulse", 32'(rv0[0]), 32'd0);

        // Faulting addresses on port 1, W=0.
        for (int i = 0; i < 3; i++) begin
            v1[0] = 1'b1;
            a1[0] = faddr[i];
            #1;
            check("fault_ready", 32'(rdy1[0]), 32'd1);
            tick();
            v1[0] = 1'b0;
            check("fault_rom_addr", rom_addr[0], Base);
            tick();
            check("fault_rsp_valid", 32'(rv1[0]), 32'd1);
            check("fault_rsp_data", rd1[0], 32'd0);
            check("fault_rsp_err", 32'(re1[0]), 32'd1);
            tick();
        end

        // Last word of the ROM.
        v0[0] = 1'b1;
        a0[0] = 32'h0040_00FC;
        #1;
        tick();
        v0[0] = 1'b0;
        check("last_rom_addr", rom_addr[0], 32'h0040_00FC);
        tick();
        check("last_rsp_data", rd0[0], rom_word(32'd63));
        check("last_rsp_err", 32'(re0[0]), 32'd0);
        tick(); tick();

        // Wait states, W=3: back-to-back reads on port 0.
        v0[1] = 1'b1;
        a0[1] = 32'h0040_0000;
        #1;
        check("w3_ready_first", 32'(rdy0[1]), 32'd1);
        tick();
        a0[1] = 32'h0040_0004;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("w3_ready_gap", 32'(rdy0[1]), 32'd0);
            tick();
        end
        check("w3_ready_second", 32'(rdy0[1]), 32'd1);
        check("w3_no_early_rsp", 32'(rv0[1]), 32'd0);
        tick();
        check("w3_rsp1_valid", 32'(rv0[1]), 32'd1);
        check("w3_rsp1_data", rd0[1], rom_word(32'd0));
        check("w3_ready_after", 32'(rdy0[1]), 32'd0);
        v0[1] = 1'b0;
        tick(); tick(); tick(); tick();
        check("w3_rsp2_valid", 32'(rv0[1]), 32'd1);
        check("w3_rsp2_data", rd0[1], rom_word(32'd1));
        tick(); tick();

        // Reset two cycles into a W=3 access: the read must vanish.
        v1[1] = 1'b1;
        a1[1] = 32'h0040_0010;
        #1;
        check("abort_ready", 32'(rdy1[1]), 32'd1);
        tick();
        v1[1] = 1'b0;
        tick(); tick();
        reset = 1'b0;
        sb.delete();
        tick();
        check_reset_vals(1, "abort");
        tick();
        reset = 1'b1;
        tick(); tick(); tick(); tick(); tick();

        // Next request after release completes normally.
        v1[1] = 1'b1;
        #1;
        check("post_reset_ready", 32'(rdy1[1]), 32'd1);
        tick();
        v1[1] = 1'b0;
        tick(); tick(); tick(); tick();
        check("post_reset_rsp_valid", 32'(rv1[1]), 32'd1);
        check("post_reset_rsp_data", rd1[1], rom_word(32'd4));
        check("post_reset_rsp_err", 32'(re1[1]), 32'd0);
        tick(); tick(); tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
